// File: rtl/bcd_clock_counter.sv
// rtl/bcd_clock_counter.sv - prescaled BCD HH:MM:SS clock with 24h/12h modes and set inputs
// Prescaler wrap advances one second; manual increments take priority over a coinciding wrap.
module bcd_clock_counter #(
   parameter int CLK_HZ  = 12000000,
   parameter int TICK_HZ = 1,
   parameter int HOUR_24 = 1
) (
   input  logic       hwclk,
   input  logic       rst,
   input  logic       run,
   input  logic       inc_min,
   input  logic       inc_hour,
   output logic       tick,
   output logic [3:0] sec_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [2:0] min_tens,
   output logic [3:0] hr_ones,
   output logic [1:0] hr_tens,
   output logic       pm,
   output logic       day_pulse
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_MAX   = PW'(DIV - 1);
   localparam logic [1:0]    HR_TENS_RST = (HOUR_24 != 0) ? 2'd0 : 2'd1;
   localparam logic [3:0]    HR_ONES_RST = (HOUR_24 != 0) ? 4'd0 : 4'd2;

   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic          day_q, day_d;
   logic          pm_q, pm_d;
   logic [3:0]    sec_ones_q, sec_ones_d;
   logic [2:0]    sec_tens_q, sec_tens_d;
   logic [3:0]    min_ones_q, min_ones_d;
   logic [2:0]    min_tens_q, min_tens_d;
   logic [3:0]    hr_ones_q, hr_ones_d;
   logic [1:0]    hr_tens_q, hr_tens_d;

   logic wrap, advance, sec_carry, min_step, min_carry, hour_step;

   always_comb begin
      wrap       = run && (presc_q == PRESC_MAX);
      advance    = wrap && !inc_min && !inc_hour;
      presc_d    = (!run || inc_min || wrap) ? '0 : presc_q + 1'b1;
      tick_d     = advance;
      day_d      = 1'b0;
      pm_d       = pm_q;
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      min_ones_d = min_ones_q;
      min_tens_d = min_tens_q;
      hr_ones_d  = hr_ones_q;
      hr_tens_d  = hr_tens_q;

      sec_carry = advance && (sec_ones_q == 4'd9) && (sec_tens_q == 3'd5);
      if (inc_min) begin
         sec_ones_d = 4'd0;
         sec_tens_d = 3'd0;
      end else if (advance) begin
         if (sec_ones_q == 4'd9) begin
            sec_ones_d = 4'd0;
            sec_tens_d = (sec_tens_q == 3'd5) ? 3'd0 : sec_tens_q + 3'd1;
         end else begin
            sec_ones_d = sec_ones_q + 4'd1;
         end
      end

      // inc_min wraps minutes without touching hours; only a seconds carry propagates
      min_step  = inc_min || sec_carry;
      min_carry = sec_carry && (min_ones_q == 4'd9) && (min_tens_q == 3'd5);
      if (min_step) begin
         if (min_ones_q == 4'd9) begin
            min_ones_d = 4'd0;
            min_tens_d = (min_tens_q == 3'd5) ? 3'd0 : min_tens_q + 3'd1;
         end else begin
            min_ones_d = min_ones_q + 4'd1;
         end
      end

      hour_step = inc_hour || min_carry;
      if (hour_step) begin
         if (HOUR_24 != 0) begin
            if (hr_tens_q == 2'd2 && hr_ones_q == 4'd3) begin
               hr_tens_d = 2'd0;
               hr_ones_d = 4'd0;
               day_d     = min_carry;
            end else if (hr_ones_q == 4'd9) begin
               hr_tens_d = hr_tens_q + 2'd1;
               hr_ones_d = 4'd0;
            end else begin
               hr_ones_d = hr_ones_q + 4'd1;
            end
         end else begin
            if (hr_tens_q == 2'd1 && hr_ones_q == 4'd2) begin
               hr_tens_d = 2'd0;
               hr_ones_d = 4'd1;
            end else if (hr_tens_q == 2'd1 && hr_ones_q == 4'd1) begin
               // 11 -> 12 flips am/pm; the pm -> am flip by carry ends the day
               hr_ones_d = 4'd2;
               pm_d      = !pm_q;
               day_d     = min_carry && pm_q;
            end else if (hr_ones_q == 4'd9) begin
               hr_tens_d = 2'd1;
               hr_ones_d = 4'd0;
            end else begin
               hr_ones_d = hr_ones_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         presc_q    <= '0;
         tick_q     <= 1'b0;
         day_q      <= 1'b0;
         pm_q       <= 1'b0;
         sec_ones_q <= 4'd0;
         sec_tens_q <= 3'd0;
         min_ones_q <= 4'd0;
         min_tens_q <= 3'd0;
         hr_ones_q  <= HR_ONES_RST;
         hr_tens_q  <= HR_TENS_RST;
      end else begin
         presc_q    <= presc_d;
         tick_q     <= tick_d;
         day_q      <= day_d;
         pm_q       <= pm_d;
         sec_ones_q <= sec_ones_d;
         sec_tens_q <= sec_tens_d;
         min_ones_q <= min_ones_d;
         min_tens_q <= min_tens_d;
         hr_ones_q  <= hr_ones_d;
         hr_tens_q  <= hr_tens_d;
      end
   end

   assign tick      = tick_q;
   assign day_pulse = day_q;
   assign pm        = pm_q;
   assign sec_ones  = sec_ones_q;
   assign sec_tens  = sec_tens_q;
   assign min_ones  = min_ones_q;
   assign min_tens  = min_tens_q;
   assign hr_ones   = hr_ones_q;
   assign hr_tens   = hr_tens_q;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// tb/tb_bcd_clock_counter.sv - scoreboard bench for 24h and 12h instances sharing one stimulus
module tb_bcd_clock_counter;

   localparam int DIV = 10;

   logic hwclk = 1'b0;
   logic rst = 1'b1, run = 1'b0, inc_min = 1'b0, inc_hour = 1'b0;

   logic       tick_a, pm_a, day_a, tick_b, pm_b, day_b;
   logic [3:0] sec_ones_a, min_ones_a, hr_ones_a, sec_ones_b, min_ones_b, hr_ones_b;
   logic [2:0] sec_tens_a, min_tens_a, sec_tens_b, min_tens_b;
   logic [1:0] hr_tens_a, hr_tens_b;

   always #5 hwclk = ~hwclk;

   bcd_clock_counter #(.CLK_HZ(10), .TICK_HZ(1), .HOUR_24(1)) u_dut24 (
      .hwclk(hwclk), .rst(rst), .run(run), .inc_min(inc_min), .inc_hour(inc_hour),
      .tick(tick_a), .sec_ones(sec_ones_a), .sec_tens(sec_tens_a),
      .min_ones(min_ones_a), .min_tens(min_tens_a), .hr_ones(hr_ones_a),
      .hr_tens(hr_tens_a), .pm(pm_a), .day_pulse(day_a));

   bcd_clock_counter #(.CLK_HZ(10), .TICK_HZ(1), .HOUR_24(0)) u_dut12 (
      .hwclk(hwclk), .rst(rst), .run(run), .inc_min(inc_min), .inc_hour(inc_hour),
      .tick(tick_b), .sec_ones(sec_ones_b), .sec_tens(sec_tens_b),
      .min_ones(min_ones_b), .min_tens(min_tens_b), .hr_ones(hr_ones_b),
      .hr_tens(hr_tens_b), .pm(pm_b), .day_pulse(day_b));

   typedef struct { int t; bit tk; bit dy; } exp_t;
   exp_t exp_q[$];
   int   t_m = 0, presc_m = 0;
   int   checks = 0, errors = 0;

   function automatic logic [22:0] pack(bit tk, bit dy, bit p, int h, int m, int s);
      return {tk, dy, p, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [22:0] exp24(exp_t e);
      return pack(e.tk, e.dy, 1'b0, e.t / 3600, (e.t / 60) % 60, e.t % 60);
   endfunction

   function automatic logic [22:0] exp12(exp_t e);
      int h24, h12;
      h24 = e.t / 3600;
      h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
      return pack(e.tk, e.dy, h24 >= 12, h12, (e.t / 60) % 60, e.t % 60);
   endfunction

   function automatic logic [22:0] act_a();
      return {tick_a, day_a, pm_a, hr_tens_a, hr_ones_a, min_tens_a, min_ones_a, sec_tens_a, sec_ones_a};
   endfunction

   function automatic logic [22:0] act_b();
      return {tick_b, day_b, pm_b, hr_tens_b, hr_ones_b, min_tens_b, min_ones_b, sec_tens_b, sec_ones_b};
   endfunction

   // time kept as seconds-of-day; both display modes are derived from it
   task automatic model_loop();
      forever begin
         @(posedge hwclk or posedge rst);
         if (rst) begin
            t_m = 0;
            presc_m = 0;
            exp_q.delete();
         end else begin
            bit wrap, tk, dy;
            int h, m, s;
            wrap = run && (presc_m == DIV - 1);
            tk = 1'b0;
            dy = 1'b0;
            if (inc_min || inc_hour) begin
               h = t_m / 3600; m = (t_m / 60) % 60; s = t_m % 60;
               if (inc_min) begin m = (m + 1) % 60; s = 0; end
               if (inc_hour) h = (h + 1) % 24;
               t_m = h * 3600 + m * 60 + s;
            end else if (wrap) begin
               tk = 1'b1;
               dy = (t_m == 86399);
               t_m = (t_m + 1) % 86400;
            end
            presc_m = (!run || inc_min || wrap) ? 0 : presc_m + 1;
            exp_q.push_back('{t_m, tk, dy});
         end
      end
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge hwclk);
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({act_a(), act_b()} !== {exp24(e), exp12(e)}) begin
               errors++;
               $display("FAIL scoreboard t=%0d actual=%h expected=%h", e.t, {act_a(), act_b()}, {exp24(e), exp12(e)});
            end
         end
      end
   endtask

   task automatic set_time(input int h, input int m);
      int hc, mc;
      @(negedge hwclk);
      run = 1'b0;
      hc = (h - t_m / 3600 + 24) % 24;
      mc = ((m - (t_m / 60) % 60 + 59) % 60) + 1;
      inc_hour = 1'b1;
      repeat (hc) @(negedge hwclk);
      inc_hour = 1'b0;
      inc_min = 1'b1;
      repeat (mc) @(negedge hwclk);
      inc_min = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge hwclk);
      checks++;
      if (act_a() !== pack(0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL reset_24h actual=%h expected=%h", act_a(), pack(0, 0, 0, 0, 0, 0));
      end
      checks++;
      if (act_b() !== pack(0, 0, 0, 12, 0, 0)) begin
         errors++; $display("FAIL reset_12h actual=%h expected=%h", act_b(), pack(0, 0, 0, 12, 0, 0));
      end
   endtask

   task automatic test_first_tick();
      int n;
      run = 1'b1;
      rst = 1'b0;
      n = 0;
      do begin @(negedge hwclk); n++; end while (!tick_a && n < 20);
      checks++;
      if (n !== 10) begin errors++; $display("FAIL first_tick_cycle actual=%0d expected=10", n); end
      checks++;
      if (act_a() !== pack(1, 0, 0, 0, 0, 1)) begin
         errors++; $display("FAIL first_tick_time actual=%h expected=%h", act_a(), pack(1, 0, 0, 0, 0, 1));
      end
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin @(negedge hwclk); n++; end while (!tick_a && n < 20);
         checks++;
         if (n !== DIV) begin errors++; $display("FAIL tick_period actual=%0d expected=%0d", n, DIV); end
      end
   endtask

   task automatic test_pm_rollover();
      set_time(11, 59);
      run = 1'b1;
      for (int i = 0; i < 700; i++) begin @(negedge hwclk); if (pm_b) break; end
      checks++;
      if (act_b() !== pack(1, 0, 1, 12, 0, 0)) begin
         errors++; $display("FAIL pm_set_12h actual=%h expected=%h", act_b(), pack(1, 0, 1, 12, 0, 0));
      end
      checks++;
      if (act_a() !== pack(1, 0, 0, 12, 0, 0)) begin
         errors++; $display("FAIL noon_24h actual=%h expected=%h", act_a(), pack(1, 0, 0, 12, 0, 0));
      end
   endtask

   task automatic test_day_rollover();
      set_time(23, 59);
      run = 1'b1;
      for (int i = 0; i < 700; i++) begin @(negedge hwclk); if (day_a) break; end
      checks++;
      if (act_a() !== pack(1, 1, 0, 0, 0, 0)) begin
         errors++; $display("FAIL day_24h actual=%h expected=%h", act_a(), pack(1, 1, 0, 0, 0, 0));
      end
      checks++;
      if (act_b() !== pack(1, 1, 0, 12, 0, 0)) begin
         errors++; $display("FAIL day_12h actual=%h expected=%h", act_b(), pack(1, 1, 0, 12, 0, 0));
      end
      @(negedge hwclk);
      checks++;
      if ({day_a, day_b} !== 2'b00) begin
         errors++; $display("FAIL day_pulse_width actual=%b expected=00", {day_a, day_b});
      end
   endtask

   task automatic test_inc_min();
      int n;
      for (int i = 0; i < 500; i++) begin
         @(negedge hwclk);
         if (tick_a && sec_tens_a == 3'd3 && sec_ones_a == 4'd7) break;
      end
      repeat (4) @(negedge hwclk);
      inc_min = 1'b1;
      @(negedge hwclk);
      checks++;
      if (act_a() !== pack(0, 0, 0, 0, 1, 0)) begin
         errors++; $display("FAIL inc_min_first actual=%h expected=%h", act_a(), pack(0, 0, 0, 0, 1, 0));
      end
      repeat (59) @(negedge hwclk);
      inc_min = 1'b0;
      checks++;
      if ({act_a(), act_b()} !== {pack(0, 0, 0, 0, 0, 0), pack(0, 0, 0, 12, 0, 0)}) begin
         errors++; $display("FAIL inc_min_wrap actual=%h expected=%h", {act_a(), act_b()},
                            {pack(0, 0, 0, 0, 0, 0), pack(0, 0, 0, 12, 0, 0)});
      end
      n = 0;
      do begin @(negedge hwclk); n++; end while (!tick_a && n < 20);
      checks++;
      if (n !== DIV) begin errors++; $display("FAIL inc_min_presc_clear actual=%0d expected=%0d", n, DIV); end
   endtask

   task automatic test_run_stop();
      int n, ticks;
      for (int i = 0; i < 100; i++) begin @(negedge hwclk); if (tick_a && sec_ones_a == 4'd5) break; end
      run = 1'b0;
      ticks = 0;
      repeat (50) begin @(negedge hwclk); if (tick_a || tick_b) ticks++; end
      checks++;
      if (ticks !== 0) begin errors++; $display("FAIL stop_no_tick actual=%0d expected=0", ticks); end
      checks++;
      if (act_a() !== pack(0, 0, 0, 0, 0, 5)) begin
         errors++; $display("FAIL stop_hold actual=%h expected=%h", act_a(), pack(0, 0, 0, 0, 0, 5));
      end
      run = 1'b1;
      n = 0;
      do begin @(negedge hwclk); n++; end while (!tick_a && n < 20);
      checks++;
      if (n !== DIV || act_a() !== pack(1, 0, 0, 0, 0, 6)) begin
         errors++; $display("FAIL restart_tick actual=%0d/%h expected=%0d/%h", n, act_a(), DIV, pack(1, 0, 0, 0, 0, 6));
      end
   endtask

   task automatic test_inc_hour_wrap();
      set_time(23, 59);
      run = 1'b1;
      for (int i = 0; i < 700; i++) begin
         @(negedge hwclk);
         if (tick_a && sec_tens_a == 3'd5 && sec_ones_a == 4'd9) break;
      end
      repeat (9) @(negedge hwclk);
      inc_hour = 1'b1;
      @(negedge hwclk);
      inc_hour = 1'b0;
      checks++;
      if ({act_a(), act_b()} !== {pack(0, 0, 0, 0, 59, 59), pack(0, 0, 0, 12, 59, 59)}) begin
         errors++; $display("FAIL inc_hour_at_wrap actual=%h expected=%h", {act_a(), act_b()},
                            {pack(0, 0, 0, 0, 59, 59), pack(0, 0, 0, 12, 59, 59)});
      end
      repeat (3) @(negedge hwclk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({act_a(), act_b()} !== {pack(0, 0, 0, 0, 0, 0), pack(0, 0, 0, 12, 0, 0)}) begin
         errors++; $display("FAIL async_reset actual=%h expected=%h", {act_a(), act_b()},
                            {pack(0, 0, 0, 0, 0, 0), pack(0, 0, 0, 12, 0, 0)});
      end
   endtask

   initial begin
      fork
         model_loop();
         monitor_loop();
      join_none
      test_reset();
      test_first_tick();
      test_pm_rollover();
      test_day_rollover();
      test_inc_min();
      test_run_stop();
      test_inc_hour_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
